// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, FSM state type and
// access decode helpers for the data memory load/store unit.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_BEAT2
  } dmem_state_e;

  function automatic logic [3:0] access_bytes(
    input logic [2:0] f3
  );
    return 4'd1 << f3[1:0];
  endfunction

  function automatic logic funct3_legal(
    input logic [2:0] f3,
    input logic       we,
    input int         data_w
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_D:             ok = (data_w == 64);
      F3_BU, F3_HU:     ok = !we;
      F3_WU:            ok = !we && (data_w == 64);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: NB-lane byte-enabled single-port synchronous RAM.
// Ports: clk, en, we[NB-1:0] (any bit set = write), addr, wdata, rdata (1-cycle).
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int NB = 4,
  parameter int AW = 7
) (
  input  logic            clk,
  input  logic            en,
  input  logic [NB-1:0]   we,
  input  logic [AW-1:0]   addr,
  input  logic [8*NB-1:0] wdata,
  output logic [8*NB-1:0] rdata
);

  logic [8*NB-1:0] r_mem [2**AW];

  // rdata only moves on a read so a response stays stable afterwards
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int b = 0; b < NB; b++) begin
          if (we[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory + load/store unit, valid/ready request, 1-cycle response.
// Ports: clk, reset (sync, high), req_valid/ready/we/funct3/addr/wdata,
//        rsp_valid/rdata/err. Option: DMEM_MISALIGN_SPLIT_EN (two-beat crossings).
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB  = DATA_W / 8;
  localparam int OW  = $clog2(NB);
  localparam int WA  = ADDR_W - OW;
  localparam int DL  = $clog2(DATA_W);
  localparam int BE2 = 2 * NB;

  dmem_state_e r_state, w_next;

  logic [2:0]        r_f3;
  logic [OW-1:0]     r_off;
  logic              r_we;
  logic              r_err;
  logic              r_zero;
  logic              r_split;
  logic [WA-1:0]     r_wa2;
  logic [NB-1:0]     r_hbe;
  logic [DATA_W-1:0] r_hwd;
  logic [DATA_W-1:0] r_lo;

  logic [3:0]          w_size;
  logic [OW-1:0]       w_off;
  logic [WA-1:0]       w_wa;
  logic                w_legal;
  logic                w_err;
  logic                w_split;
  logic                w_acc;
  logic [BE2-1:0]      w_smask;
  logic [BE2-1:0]      w_be;
  logic [2*DATA_W-1:0] w_wd;

  logic              w_ben;
  logic [NB-1:0]     w_bwe;
  logic [WA-1:0]     w_baddr;
  logic [DATA_W-1:0] w_bwd;
  logic [DATA_W-1:0] w_brd;

  logic [2*DATA_W-1:0] w_cat;
  logic [DATA_W-1:0]   w_lane;
  logic [DATA_W-1:0]   w_ext;
  logic [DL-1:0]       w_msb;
  logic                w_sb;

  assign w_size  = access_bytes(req_funct3);
  assign w_off   = req_addr[OW-1:0];
  assign w_wa    = req_addr[ADDR_W-1:OW];
  assign w_legal = funct3_legal(req_funct3, req_we, DATA_W);

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [4:0] w_end;
  logic       w_cross;
  logic       w_last;

  assign w_end   = 5'(w_off) + 5'(w_size);
  assign w_cross = w_end > 5'(NB);
  assign w_last  = &w_wa;
  // a crossing from the top word would wrap: reject it
  assign w_err   = !w_legal || (w_cross && w_last);
  assign w_split = w_legal && w_cross && !w_last;
`else
  logic [OW-1:0] w_amask;

  assign w_amask = OW'(w_size - 4'd1);
  assign w_err   = !w_legal || (|(w_off & w_amask));
  assign w_split = 1'b0;
`endif

  // double-width lanes: low half is beat 1, high half beat 2
  assign w_smask = BE2'((16'd1 << w_size) - 16'd1);
  assign w_be    = w_smask << w_off;
  assign w_wd    = {{DATA_W{1'b0}}, req_wdata} << {w_off, 3'b000};

  assign req_ready = !reset && (r_state != S_BEAT2);
  assign w_acc     = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (w_acc) w_next = w_split ? S_BEAT2 : S_RESP;
        else       w_next = S_IDLE;
      end
      S_BEAT2: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b1;
      r_err  <= 1'b0;
    end else if (w_acc) begin
      r_zero <= w_err || req_we;
      r_err  <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_f3    <= req_funct3;
      r_off   <= w_off;
      r_we    <= req_we;
      r_split <= w_split;
      r_wa2   <= w_wa + 1'b1;
      r_hbe   <= w_be[BE2-1:NB];
      r_hwd   <= w_wd[2*DATA_W-1:DATA_W];
    end
    if (r_state == S_BEAT2) r_lo <= w_brd;
  end

  // beat 2 owns the port; reset in BEAT2 drops it
  always_comb begin
    w_ben   = 1'b0;
    w_bwe   = '0;
    w_baddr = w_wa;
    w_bwd   = w_wd[DATA_W-1:0];
    if (!reset && r_state == S_BEAT2) begin
      w_ben   = 1'b1;
      w_bwe   = r_we ? r_hbe : '0;
      w_baddr = r_wa2;
      w_bwd   = r_hwd;
    end else if (w_acc && !w_err) begin
      w_ben = 1'b1;
      w_bwe = req_we ? w_be[NB-1:0] : '0;
    end
  end

  dmem_bank #(
    .NB (NB),
    .AW (WA)
  ) u_bank (
    .clk   (clk),
    .en    (w_ben),
    .we    (w_bwe),
    .addr  (w_baddr),
    .wdata (w_bwd),
    .rdata (w_brd)
  );

  assign w_cat  = r_split ? {w_brd, r_lo}
                          : {{DATA_W{1'b0}}, w_brd};
  assign w_lane = DATA_W'(w_cat >> {r_off, 3'b000});

  always_comb begin
    unique case (r_f3[1:0])
      2'd0:    w_msb = DL'(7);
      2'd1:    w_msb = DL'(15);
      2'd2:    w_msb = DL'(31);
      default: w_msb = DL'(DATA_W - 1);
    endcase
    w_sb  = !r_f3[2] && w_lane[w_msb];
    w_ext = w_lane;
    for (int i = 0; i < DATA_W; i++) begin
      if (i > int'(w_msb)) w_ext[i] = w_sb;
    end
  end

  assign rsp_valid = !reset && (r_state == S_RESP);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = (reset || r_zero) ? '0 : w_ext;

endmodule
